// File: rtl/special_counter_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// special_counter_seq_ctrl_pkg
// Shared definitions for the special counter sequencer: default geometry,
// sequencer state encoding and a helper that checks a requested sequence
// length against the table depth.
// ---------------------------------------------------------------------------
package special_counter_seq_ctrl_pkg;

  localparam int SC_WIDTH = 3;
  localparam int SC_DEPTH = 8;
  localparam int SC_AW    = 3;
  localparam int SC_DIV   = 4;
  localparam int SC_LAP_W = 4;
  localparam int SC_LEN_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seqState_t;

  // A sequence must cover at least one entry and may not run past the table.
  function automatic logic lenLegal(input logic [SC_LEN_W-1:0] len, input int depth);
    return (len != '0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/special_counter_seq_ctrl_tick_div.sv
// ---------------------------------------------------------------------------
// tick_div
// Prescaler that counts 0..DIV-1 while enabled and raises a one-cycle tick
// during the terminal count. A synchronous clear returns it to zero.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset
//   i_clr   synchronous clear to zero (has priority over i_en)
//   i_en    count enable
//   o_tick  high while enabled and at count DIV-1
// ---------------------------------------------------------------------------
module tick_div #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_count;
  logic          w_terminal;

  assign w_terminal = (r_count == CW'(DIV - 1));

  // Free-running modulo-DIV counter; with DIV=1 it sits at zero and ticks
  // every enabled cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_terminal ? '0 : r_count + CW'(1);
    end
  end

  assign o_tick = i_en && w_terminal;

endmodule

// File: rtl/special_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// special_counter_seq_ctrl
// Sequencer for the 3-bit special counter datapath. Holds a programmable
// table of counter values and steps o_q through table[0..len-1] at a
// prescaled rate, for a finite number of laps or until stopped.
// Ports:
//   i_clk, i_rst            clock / asynchronous active-high reset
//   i_cfg_we/addr/data      table write port, honoured only while idle
//   i_cfg_len               sequence length (1..DEPTH), sampled at start
//   i_laps                  laps to run, 0 = endless; sampled at start
//   i_start, i_stop         level controls; stop has priority
//   o_q                     current counter value
//   o_step                  one-cycle pulse each time o_q advances
//   o_busy                  high while running
//   o_done                  one-cycle pulse when the final lap completes
//   o_cfg_err               one-cycle pulse on an illegal start length or a
//                           table write attempted while not idle
// ---------------------------------------------------------------------------
module special_counter_seq_ctrl
  import special_counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int DEPTH = SC_DEPTH,
  parameter int DIV   = SC_DIV,
  parameter int LAP_W = SC_LAP_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_we,
  input  logic [$clog2(DEPTH)-1:0] i_cfg_addr,
  input  logic [WIDTH-1:0]         i_cfg_data,
  input  logic [SC_LEN_W-1:0]      i_cfg_len,
  input  logic [LAP_W-1:0]         i_laps,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic [WIDTH-1:0]         o_q,
  output logic                     o_step,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_cfg_err
);

  localparam int AW = $clog2(DEPTH);

  seqState_t            r_state;
  seqState_t            w_nextState;
  logic [WIDTH-1:0]     r_table [DEPTH];
  logic [WIDTH-1:0]     r_q;
  logic [AW-1:0]        r_idx;
  logic [LAP_W-1:0]     r_lap;
  logic [SC_LEN_W-1:0]  r_len;
  logic [LAP_W-1:0]     r_laps;
  logic                 r_step;
  logic                 r_cfgErr;

  logic                 w_tick;
  logic                 w_lenOk;
  logic                 w_startGo;
  logic                 w_wrap;
  logic [AW-1:0]        w_nextIdx;
  logic                 w_lastLap;
  logic                 w_advance;
  logic                 w_finish;

  // The prescaler is held at zero outside RUN so the first step always
  // lands DIV cycles after the run begins.
  tick_div #(
    .DIV (DIV)
  ) u_tickDiv (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (r_state != S_RUN),
    .i_en   (r_state == S_RUN),
    .o_tick (w_tick)
  );

  assign w_lenOk   = lenLegal(i_cfg_len, DEPTH);
  assign w_startGo = (r_state == S_IDLE) && i_start && !i_stop && w_lenOk;
  assign w_wrap    = (SC_LEN_W'(r_idx) == (r_len - SC_LEN_W'(1)));
  assign w_nextIdx = w_wrap ? '0 : r_idx + AW'(1);
  // The lap being finished is r_lap; the run ends when that makes r_laps.
  assign w_lastLap = (r_laps != '0) && ((r_lap + LAP_W'(1)) == r_laps);
  // Stop takes priority over a coinciding tick so o_q freezes where it was.
  assign w_advance = (r_state == S_RUN) && !i_stop && w_tick;
  assign w_finish  = w_advance && w_wrap && w_lastLap;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle before returning to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_startGo) w_nextState = S_RUN;
      S_RUN: begin
        if (i_stop) begin
          w_nextState = S_IDLE;
        end else if (w_finish) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Outputs decoded from state plus the registered pulses.
  always_comb begin
    o_busy    = (r_state == S_RUN);
    o_done    = (r_state == S_DONE);
    o_q       = r_q;
    o_step    = r_step;
    o_cfg_err = r_cfgErr;
  end

  // Table, counter value, index and lap bookkeeping. The table only accepts
  // writes while idle so a running sequence never sees it change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= WIDTH'(i);
      end
      r_q      <= '0;
      r_idx    <= '0;
      r_lap    <= '0;
      r_len    <= '0;
      r_laps   <= '0;
      r_step   <= 1'b0;
      r_cfgErr <= 1'b0;
    end else begin
      r_step   <= w_advance;
      r_cfgErr <= ((r_state == S_IDLE) && i_start && !i_stop && !w_lenOk) ||
                  ((r_state != S_IDLE) && i_cfg_we);
      if (r_state == S_IDLE) begin
        if (i_cfg_we) begin
          r_table[i_cfg_addr] <= i_cfg_data;
        end
        if (w_startGo) begin
          r_q    <= r_table[0];
          r_idx  <= '0;
          r_lap  <= '0;
          r_len  <= i_cfg_len;
          r_laps <= i_laps;
        end
      end else if (w_advance) begin
        r_idx <= w_nextIdx;
        r_q   <= r_table[w_nextIdx];
        // Endless runs saturate the lap count rather than wrapping.
        if (w_wrap && (r_lap != '1)) begin
          r_lap <= r_lap + LAP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_special_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_special_counter_seq_ctrl
// Self-checking bench for the special counter sequencer. Expected outputs are
// computed from the table contents and elapsed cycle count: after a start,
// c cycles in, q is table[(c/DIV) mod len], step fires every DIV cycles and a
// finite run ends after len*laps steps.
// ---------------------------------------------------------------------------
module tb_special_counter_seq_ctrl;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;
  localparam int LAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfgWe = 1'b0;
  logic [2:0]       cfgAddr = '0;
  logic [WIDTH-1:0] cfgData = '0;
  logic [3:0]       cfgLen = '0;
  logic [LAP_W-1:0] laps = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] q;
  logic             step;
  logic             busy;
  logic             done;
  logic             cfgErr;

  int errors = 0;
  int checks = 0;
  int modelTable [DEPTH];

  always #5 clk = ~clk;

  special_counter_seq_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DIV   (DIV),
    .LAP_W (LAP_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cfg_we   (cfgWe),
    .i_cfg_addr (cfgAddr),
    .i_cfg_data (cfgData),
    .i_cfg_len  (cfgLen),
    .i_laps     (laps),
    .i_start    (start),
    .i_stop     (stop),
    .o_q        (q),
    .o_step     (step),
    .o_busy     (busy),
    .o_done     (done),
    .o_cfg_err  (cfgErr)
  );

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) modelTable[i] = i;
  endtask

  // Hold reset across a clock edge and confirm the idle outputs.
  task automatic resetDut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_q", 32'(q), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_step", 32'(step), 0);
    checkOutput("reset_cfg_err", 32'(cfgErr), 0);
    rst = 1'b0;
    resetModel();
  endtask

  task automatic writeTable(input int addr, input int data);
    @(negedge clk);
    cfgWe = 1'b1;
    cfgAddr = 3'(addr);
    cfgData = WIDTH'(data);
    @(negedge clk);
    cfgWe = 1'b0;
    checkOutput("idle_write_cfg_err", 32'(cfgErr), 0);
    modelTable[addr] = data;
  endtask

  task automatic illegalStart(input int len);
    @(negedge clk);
    cfgLen = 4'(len);
    laps = LAP_W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput($sformatf("illegal_len%0d_cfg_err", len), 32'(cfgErr), 1);
    checkOutput($sformatf("illegal_len%0d_busy", len), 32'(busy), 0);
    @(negedge clk);
    checkOutput($sformatf("illegal_len%0d_cfg_err_clear", len), 32'(cfgErr), 0);
    checkOutput($sformatf("illegal_len%0d_busy_after", len), 32'(busy), 0);
  endtask

  // Start a run and check every cycle against the arithmetic model.
  // stopAt/weAt/rstAt < 0 disable that event; otherwise it is applied at the
  // given cycle count after the start edge.
  task automatic applyStimulus(input int len, input int nLaps, input int stopAt,
                               input int weAt, input int rstAt);
    int totalSteps;
    int limit;
    int k;
    int expQ;
    int expStep;
    int expBusy;
    int expDone;
    int expErr;
    @(negedge clk);
    cfgLen = 4'(len);
    laps = LAP_W'(nLaps);
    stop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    totalSteps = len * nLaps;
    limit = (nLaps == 0) ? 1000 : totalSteps * DIV + 1;
    for (int c = 0; c <= limit; c++) begin
      if (c > 0) @(negedge clk);
      cfgWe = 1'b0;
      k = c / DIV;
      if (nLaps != 0 && k > totalSteps) k = totalSteps;
      expQ    = modelTable[k % len];
      expStep = ((c > 0) && (c % DIV == 0) && (nLaps == 0 || c <= totalSteps * DIV)) ? 1 : 0;
      expBusy = ((nLaps == 0) || (c < totalSteps * DIV)) ? 1 : 0;
      expDone = ((nLaps != 0) && (c == totalSteps * DIV)) ? 1 : 0;
      expErr  = ((weAt >= 0) && (c == weAt + 1)) ? 1 : 0;
      checkOutput($sformatf("run_q_c%0d", c), 32'(q), expQ);
      checkOutput($sformatf("run_step_c%0d", c), 32'(step), expStep);
      checkOutput($sformatf("run_busy_c%0d", c), 32'(busy), expBusy);
      checkOutput($sformatf("run_done_c%0d", c), 32'(done), expDone);
      checkOutput($sformatf("run_cfg_err_c%0d", c), 32'(cfgErr), expErr);
      if (c == weAt) begin
        cfgWe = 1'b1;
        cfgAddr = 3'd0;
        cfgData = WIDTH'($urandom_range(0, 7));
      end
      if (c == stopAt) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checkOutput("stop_busy", 32'(busy), 0);
        checkOutput("stop_done", 32'(done), 0);
        checkOutput("stop_step", 32'(step), 0);
        checkOutput("stop_q", 32'(q), expQ);
        repeat (2) @(negedge clk);
        checkOutput("stop_q_frozen", 32'(q), expQ);
        checkOutput("stop_done_later", 32'(done), 0);
        return;
      end
      if (c == rstAt) begin
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_q", 32'(q), 0);
        checkOutput("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        return;
      end
    end
  endtask

  initial begin
    resetModel();
    resetDut();

    $display("[TB] full table, one lap");
    applyStimulus(8, 1, -1, -1, -1);

    $display("[TB] table {5,3,6}, two laps");
    writeTable(0, 5);
    writeTable(1, 3);
    writeTable(2, 6);
    applyStimulus(3, 2, -1, -1, -1);

    $display("[TB] endless run stopped after 20 steps");
    applyStimulus(2, 0, 20 * DIV + 1, -1, -1);

    $display("[TB] illegal lengths");
    illegalStart(0);
    illegalStart(9);

    $display("[TB] write attempted during run");
    applyStimulus(3, 3, -1, 2, -1);

    $display("[TB] single-entry sequence");
    applyStimulus(1, 3, -1, -1, -1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 3; w++) begin
        writeTable($urandom_range(0, DEPTH - 1), $urandom_range(0, 7));
      end
      applyStimulus($urandom_range(1, DEPTH), $urandom_range(1, 3), -1, -1, -1);
      applyStimulus($urandom_range(1, DEPTH), 0, $urandom_range(1, 40), -1, -1);
    end

    $display("[TB] reset mid-run then identity readback");
    resetDut();
    writeTable(4, 4);
    applyStimulus(8, 0, -1, -1, 4 * DIV + 1);
    applyStimulus(8, 1, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
